// File: rtl/kbd_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits,
// odd parity, stop, then device ack and line release.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   tx_data[7:0]      command byte, latched when tx_start is accepted
//   tx_start          request pulse, accepted only while idle
//   ps2clk, ps2data   PS/2 lines as read back at the pads
//   ps2clk_low        1 = pull ps2clk low, 0 = release
//   ps2data_low       1 = pull ps2data low, 0 = release
//   busy              high from acceptance until back in idle
//   done              one-cycle pulse: frame sent and acked
//   err               one-cycle pulse: no ack or timeout
module kbd_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       ps2clk_low,
  output logic       ps2data_low,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    RELEASE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    s_q, s_d;
  logic [9:0]    fr_q, fr_d;
  logic [3:0]    bc_q, bc_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          clk_low_q, clk_low_d;
  logic          data_low_q, data_low_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          fall;
  logic          to_hit;

  // Falling edge only after four high samples followed by four low ones;
  // this rejects glitches on the slow open-collector clock line.
  assign fall   = (s_q[7:4] == 4'hF) && (s_q[3:0] == 4'h0);
  assign to_hit = (tcnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    s_d        = {s_q[6:0], ps2clk};
    fr_d       = fr_q;
    bc_d       = bc_q;
    icnt_d     = icnt_q;
    tcnt_d     = tcnt_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        if (tx_start) begin
          // stop, odd parity, data; shifted out LSB first
          fr_d      = {1'b1, ~^tx_data, tx_data};
          bc_d      = 4'd0;
          icnt_d    = '0;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        if (icnt_q == INH_LAST) begin
          // Start bit goes out as the clock is handed back to the device.
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          tcnt_d     = '0;
          state_d    = SEND;
        end else begin
          icnt_d = icnt_q + IW'(1);
        end
      end

      SEND: begin
        if (to_hit) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (fall) begin
            data_low_d = ~fr_q[0];
            fr_d       = {1'b0, fr_q[9:1]};
            bc_d       = bc_q + 4'd1;
            // Tenth fall has just put the stop bit on the line.
            if (bc_q == 4'd9) begin
              state_d = ACK;
            end
          end
        end
      end

      ACK: begin
        if (to_hit) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (fall) begin
            if (ps2data) begin
              clk_low_d  = 1'b0;
              data_low_d = 1'b0;
              busy_d     = 1'b0;
              err_d      = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = RELEASE;
            end
          end
        end
      end

      RELEASE: begin
        // Device is finished once both lines float high together.
        if (ps2clk && ps2data) begin
          clk_low_d  = 1'b0;
          data_low_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        clk_low_d  = 1'b0;
        data_low_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      s_q        <= '0;
      fr_q       <= '0;
      bc_q       <= '0;
      icnt_q     <= '0;
      tcnt_q     <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      fr_q       <= fr_d;
      bc_q       <= bc_d;
      icnt_q     <= icnt_d;
      tcnt_q     <= tcnt_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ps2clk_low  = clk_low_q;
  assign ps2data_low = data_low_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kbd_host_tx.sv
// Bench for kbd_host_tx: device model on the PS/2 lines, timeline
// model of the expected outputs checked every cycle.
module tb_kbd_host_tx;

  localparam int INH = 20;
  localparam int TO  = 200;

  localparam int S_ERR  = 0;
  localparam int S_DONE = 1;
  localparam int S_BUSY = 2;
  localparam int S_DL   = 3;
  localparam int S_CL   = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2clk, ps2data;
  logic       ps2clk_low, ps2data_low;
  logic       busy, done, err;

  assign ps2clk  = ps2clk_low ? 1'b0 : dev_clk;
  assign ps2data = ps2data_low ? 1'b0 : dev_data;

  kbd_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2clk(ps2clk),
    .ps2data(ps2data),
    .ps2clk_low(ps2clk_low),
    .ps2data_low(ps2data_low),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int cyc;
    int sig;
    bit val;
  } ev_t;

  ev_t      evq[$];
  bit [4:0] expv = '0;

  int done_cnt = 0;
  int err_cnt  = 0;
  int last_err = 0;

  task automatic sched(input int c, input int sig, input bit v);
    ev_t e;
    int  i;
    e.cyc = c;
    e.sig = sig;
    e.val = v;
    i = evq.size();
    while (i > 0 && evq[i-1].cyc > c) i--;
    evq.insert(i, e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Compare process: apply due model events, then check all outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      while (evq.size() > 0 && evq[0].cyc <= ncyc) begin
        expv[evq[0].sig] = evq[0].val;
        void'(evq.pop_front());
      end
      n_cmp++;
      if ({ps2clk_low, ps2data_low, busy, done, err} !== expv) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL outputs cyc=%0d got=%b exp=%b", ncyc,
                   {ps2clk_low, ps2data_low, busy, done, err}, expv);
      end
    end
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      last_err = ncyc;
    end
  end

  // Line values the device must see: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] b, output int a);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    a = ncyc + 1;
    sched(a, S_CL, 1'b1);
    sched(a, S_BUSY, 1'b1);
    sched(a + INH, S_CL, 1'b0);
    sched(a + INH, S_DL, 1'b1);
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    while (evq.size() > 0 && evq[evq.size()-1].cyc > ncyc)
      void'(evq.pop_back());
    for (int s = 0; s < 5; s++) sched(ncyc + 1, s, 1'b0);
    nclk(1);
    chk("mid_reset_out", {27'd0, ps2clk_low, ps2data_low, busy, done, err},
        32'd0);
    reset    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  // One frame driven by the device model. A device pull-down seen by the
  // host filter changes outputs on the fifth edge after the drive.
  task automatic xfer(input logic [7:0] b, input bit ack, input bit poke,
                      input bit rst5, output logic [9:0] rx,
                      output logic st);
    int a, d, lo, hi;
    logic [9:0] fb;
    fb = frame_bits(b);
    rx = '0;
    st = 1'b1;
    accept(b, a);
    d = $urandom_range(8, 12);
    while (ncyc < a + INH + d) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      lo = $urandom_range(6, 7);
      hi = $urandom_range(5, 7);
      if (k == 1) st = ps2data;
      dev_clk = 1'b0;
      if (k <= 10) begin
        sched(ncyc + 5, S_DL, ~fb[k-1]);
      end else if (!ack) begin
        sched(ncyc + 5, S_BUSY, 1'b0);
        sched(ncyc + 5, S_ERR, 1'b1);
        sched(ncyc + 6, S_ERR, 1'b0);
      end
      if (poke && k == 3) begin
        nclk(1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        nclk(1);
        tx_start = 1'b0;
        nclk(lo - 2);
      end else begin
        nclk(lo);
      end
      dev_clk = 1'b1;
      if (k <= 10) rx[k-1] = ps2data;
      if (rst5 && k == 5) begin
        pulse_reset();
        return;
      end
      if (k == 10 && ack) begin
        nclk(2);
        dev_data = 1'b0;
        nclk(hi - 2);
      end else if (k == 11 && ack) begin
        nclk(2);
        dev_data = 1'b1;
        sched(ncyc + 1, S_BUSY, 1'b0);
        sched(ncyc + 1, S_DONE, 1'b1);
        sched(ncyc + 2, S_DONE, 1'b0);
        nclk(hi - 2);
      end else begin
        nclk(hi);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic run(input string nm, input logic [7:0] b, input bit ack,
                     input bit poke, input bit use_lit,
                     input logic [9:0] lit);
    int d0, e0;
    logic [9:0] rx;
    logic st;
    d0 = done_cnt;
    e0 = err_cnt;
    xfer(b, ack, poke, 1'b0, rx, st);
    nclk(4 + $urandom_range(0, 6));
    chk({nm, "_frame"}, 32'(rx), use_lit ? 32'(lit) : 32'(frame_bits(b)));
    chk({nm, "_start"}, 32'(st), 32'd0);
    chk({nm, "_done"}, done_cnt - d0, ack ? 32'd1 : 32'd0);
    chk({nm, "_err"}, err_cnt - e0, ack ? 32'd0 : 32'd1);
  endtask

  initial begin
    int a, d0, e0;
    logic [9:0] rx;
    logic st;
    logic [7:0] b;

    nclk(3);
    chk("reset_state", {27'd0, ps2clk_low, ps2data_low, busy, done, err},
        32'd0);
    chk_en = 1'b1;
    reset  = 1'b0;
    nclk(5);

    run("ed", 8'hED, 1'b1, 1'b0, 1'b1, 10'h3ED);
    run("x01", 8'h01, 1'b1, 1'b0, 1'b1, 10'h201);
    run("xff", 8'hFF, 1'b1, 1'b0, 1'b1, 10'h3FF);
    run("nack", 8'h3C, 1'b0, 1'b0, 1'b1, 10'h33C);

    e0 = err_cnt;
    d0 = done_cnt;
    accept(8'hA5, a);
    sched(a + INH + TO, S_DL, 1'b0);
    sched(a + INH + TO, S_BUSY, 1'b0);
    sched(a + INH + TO, S_ERR, 1'b1);
    sched(a + INH + TO + 1, S_ERR, 1'b0);
    while (ncyc < a + INH + TO + 5) @(negedge clk);
    chk("to_err_cnt", err_cnt - e0, 32'd1);
    chk("to_done_cnt", done_cnt - d0, 32'd0);
    chk("to_latency", last_err - (a + INH), TO);

    run("poke", 8'hF4, 1'b1, 1'b1, 1'b1, 10'h2F4);

    d0 = done_cnt;
    e0 = err_cnt;
    xfer(8'hF4, 1'b1, 1'b0, 1'b1, rx, st);
    nclk(10);
    chk("rst_done", done_cnt - d0, 32'd0);
    chk("rst_err", err_cnt - e0, 32'd0);
    run("after_rst", 8'hF4, 1'b1, 1'b0, 1'b1, 10'h2F4);

    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      run("rnd", b, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'b0, 10'h000);
    end

    nclk(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
